// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_LD = 1'b0;
  localparam logic OP_ST = 1'b1;

  localparam int unsigned DEF_LATENCY = 4;
  localparam int unsigned DEF_MEM_AW  = 10;
  // Wide enough for the maximum legal latency of 15.
  localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM; contents are not reset, only the read register.
module dmem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr,
  input  logic [MEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 1 << MEM_AW;

  logic [DATA_W-1:0] r_mem [Depth];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en && wr) begin
      r_mem[addr] <= wdata;
    end
  end

  // Read register only moves on loads, so it holds across stores and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (en && !wr) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM stage: one access at a time, fixed latency,
// stalls the pipeline while busy and pulses rd_valid on load completion.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MEM_AW  = DEF_MEM_AW,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              hlt,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic              stall,
  output logic              busy,
  output logic              err
);

  state_e            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_op;
  logic [MEM_AW-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;

  logic              w_req;
  logic              w_accept;
  logic              w_stall;
  logic              w_acc;
  logic              w_in_op;
  logic              w_acc_op;
  logic [MEM_AW-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_unused_addr;

  assign w_req    = (re | we) & ~hlt;
  assign w_accept = (r_state == IDLE) & w_req;
  // A simultaneous load+store is treated as a store.
  assign w_in_op  = we ? OP_ST : OP_LD;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall      = 1'b0;
    w_acc        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_stall    = 1'b1;
          w_cnt_next = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            w_state_next = DONE;
            w_acc        = 1'b1;
          end else begin
            w_state_next = BUSY;
          end
        end
      end
      BUSY: begin
        w_stall    = 1'b1;
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = DONE;
          w_acc        = 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= OP_LD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_op    <= w_in_op;
        r_addr  <= addr[MEM_AW-1:0];
        r_wdata <= wdata;
        if (re && we) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // With LATENCY==1 the access fires in the acceptance cycle, before capture.
  assign w_acc_op    = (r_state == IDLE) ? w_in_op : r_op;
  assign w_acc_addr  = (r_state == IDLE) ? addr[MEM_AW-1:0] : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? wdata : r_wdata;

  assign w_unused_addr = ^addr[ADDR_W-1:MEM_AW];

  dmem_array #(
    .DATA_W(DATA_W),
    .MEM_AW(MEM_AW)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (w_acc),
    .wr   (w_acc_op == OP_ST),
    .addr (w_acc_addr),
    .wdata(w_acc_wdata),
    .rdata(rdata)
  );

  assign stall    = w_stall;
  assign busy     = (r_state != IDLE);
  assign rd_valid = (r_state == DONE) & (r_op == OP_LD);
  assign err      = r_err;

endmodule
